// File: rtl/layer_store_buffer.sv
// Result buffer between the MAC array and the next-layer mux / argmax stage.
// Each load pulse captures one group of LANES MAC results into the next free
// group slot. Results are read back through a registered port that checks the
// index range and whether the group has been written.
module layer_store_buffer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 10,
    parameter int GROUPS = 2,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      ld_val,
    input  logic [LANES*DATA_W-1:0]   mac_in,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      rd_err,
    output logic [CNT_W-1:0]          wr_grp,
    output logic [CNT_W-1:0]          grp_count,
    output logic                      full,
    output logic                      overflow
);

    localparam int DEPTH = LANES * GROUPS;
    // Wide enough that the range compare and the group divide never truncate.
    localparam int IW = ADDR_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    logic [DATA_W-1:0] store [DEPTH];
    logic [GROUPS-1:0] grp_valid;

    logic              load_ok;
    logic [IW-1:0]     rd_addr_ext;
    logic [IW-1:0]     rd_grp_ext;
    logic              rd_in_range;
    logic              rd_grp_hit;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_word;

    // A load only lands when nothing of higher priority is happening and a slot is free.
    assign load_ok = ld_val & ~full & ~clr & ~rst;

    // Decode the flat read index into range, owning group and the stored word.
    always_comb begin
        rd_addr_ext = IW'(rd_addr);
        rd_in_range = (rd_addr_ext < IW'(DEPTH));
        rd_grp_ext  = rd_addr_ext / IW'(LANES);
        rd_grp_hit  = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            if (rd_grp_ext == IW'(g)) begin
                rd_grp_hit = grp_valid[g];
            end
        end
        rd_word = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (rd_addr_ext == IW'(a)) begin
                rd_word = store[a];
            end
        end
        rd_hit = rd_in_range & rd_grp_hit;
    end

    // Storage is deliberately not reset; the valid bits decide what is readable.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            for (int g = 0; g < GROUPS; g++) begin
                if (wr_grp == CNT_W'(g)) begin
                    for (int i = 0; i < LANES; i++) begin
                        store[g*LANES + i] <= mac_in[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Write pointer, group bookkeeping and the full/overflow flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_grp    <= '0;
            grp_count <= '0;
            grp_valid <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else if (ld_val) begin
            if (!full) begin
                for (int g = 0; g < GROUPS; g++) begin
                    if (wr_grp == CNT_W'(g)) begin
                        grp_valid[g] <= 1'b1;
                    end
                end
                grp_count <= grp_count + CNT_W'(1);
                if (wr_grp == LAST_GRP) begin
                    wr_grp <= '0;
                    full   <= 1'b1;
                end else begin
                    wr_grp <= wr_grp + CNT_W'(1);
                end
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered read port; uses pre-update valid bits so it is independent of same-cycle loads/clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_hit ? rd_word : '0;
                rd_err  <= ~rd_hit;
            end else begin
                rd_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_store_buffer.sv
// Directed bench for layer_store_buffer. Each step drives one cycle of inputs,
// a behavioural model predicts the outputs that step produces one edge later,
// and the prediction is queued and compared on the following falling edge.
module tb_layer_store_buffer;

    localparam int DATA_W = 8;
    localparam int LANES  = 10;
    localparam int GROUPS = 2;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = LANES * GROUPS;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clr = 1'b0;
    logic                    ld_val = 1'b0;
    logic [LANES*DATA_W-1:0] mac_in = '0;
    logic                    rd_en = 1'b0;
    logic [ADDR_W-1:0]       rd_addr = '0;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    rd_err;
    logic [CNT_W-1:0]        wr_grp;
    logic [CNT_W-1:0]        grp_count;
    logic                    full;
    logic                    overflow;

    typedef struct {
        logic              rd_valid;
        logic              rd_err;
        logic [DATA_W-1:0] rd_data;
        logic [CNT_W-1:0]  wr_grp;
        logic [CNT_W-1:0]  grp_count;
        logic              full;
        logic              overflow;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];

    logic [DATA_W-1:0] m_store [DEPTH];
    logic [GROUPS-1:0] m_valid = '0;
    int                m_wr = 0;
    int                m_cnt = 0;
    logic              m_full = 1'b0;
    logic              m_ovf = 1'b0;
    logic [DATA_W-1:0] m_rd_data = '0;

    int n_checks = 0;
    int n_pass = 0;

    layer_store_buffer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .GROUPS (GROUPS),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ld_val    (ld_val),
        .mac_in    (mac_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .wr_grp    (wr_grp),
        .grp_count (grp_count),
        .full      (full),
        .overflow  (overflow)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [LANES*DATA_W-1:0] mac_ramp(input logic [7:0] base, input logic [7:0] step);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*DATA_W +: DATA_W] = base + 8'(i) * step;
        end
        return r;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        t = tag_q.pop_front();
        checkField({t, ".rd_valid"},  32'(rd_valid),  32'(e.rd_valid));
        checkField({t, ".rd_err"},    32'(rd_err),    32'(e.rd_err));
        checkField({t, ".rd_data"},   32'(rd_data),   32'(e.rd_data));
        checkField({t, ".wr_grp"},    32'(wr_grp),    32'(e.wr_grp));
        checkField({t, ".grp_count"}, 32'(grp_count), 32'(e.grp_count));
        checkField({t, ".full"},      32'(full),      32'(e.full));
        checkField({t, ".overflow"},  32'(overflow),  32'(e.overflow));
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic c, input logic l,
                                 input logic [LANES*DATA_W-1:0] m, input logic re,
                                 input logic [ADDR_W-1:0] a);
        exp_t e;
        logic hit;
        @(negedge clk);
        checkOutput();
        rst     = r;
        clr     = c;
        ld_val  = l;
        mac_in  = m;
        rd_en   = re;
        rd_addr = a;
        if (r) begin
            m_valid   = '0;
            m_wr      = 0;
            m_cnt     = 0;
            m_full    = 1'b0;
            m_ovf     = 1'b0;
            m_rd_data = '0;
            e.rd_valid = 1'b0;
            e.rd_err   = 1'b0;
        end else begin
            if (re) begin
                if (int'(a) < DEPTH) hit = m_valid[int'(a) / LANES];
                else                 hit = 1'b0;
                m_rd_data  = hit ? m_store[a] : '0;
                e.rd_valid = 1'b1;
                e.rd_err   = ~hit;
            end else begin
                e.rd_valid = 1'b0;
                e.rd_err   = 1'b0;
            end
            if (c) begin
                m_valid = '0;
                m_wr    = 0;
                m_cnt   = 0;
                m_full  = 1'b0;
                m_ovf   = 1'b0;
            end else if (l) begin
                if (!m_full) begin
                    for (int i = 0; i < LANES; i++) begin
                        m_store[m_wr*LANES + i] = m[i*DATA_W +: DATA_W];
                    end
                    m_valid[m_wr] = 1'b1;
                    m_cnt++;
                    m_wr   = (m_wr + 1) % GROUPS;
                    m_full = (m_cnt == GROUPS);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        e.rd_data   = m_rd_data;
        e.wr_grp    = CNT_W'(m_wr);
        e.grp_count = CNT_W'(m_cnt);
        e.full      = m_full;
        e.overflow  = m_ovf;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic readAt(input string tag, input int a);
        applyStimulus(tag, 1'b0, 1'b0, 1'b0, '0, 1'b1, ADDR_W'(a));
    endtask

    task automatic loadGrp(input string tag, input logic [LANES*DATA_W-1:0] m);
        applyStimulus(tag, 1'b0, 1'b0, 1'b1, m, 1'b0, '0);
    endtask

    // Directed sequence following the block's test plan; explicit checks sample the step before.
    initial begin
        // Reset, then a read of an unwritten group.
        applyStimulus("t1_rst", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        readAt("t1_rd0", 0);
        idle("t1_idle");
        checkField("t1_rd_valid", 32'(rd_valid), 32'd1);
        checkField("t1_rd_data", 32'(rd_data), 32'd0);
        checkField("t1_rd_err", 32'(rd_err), 32'd1);
        checkField("t1_full", 32'(full), 32'd0);
        checkField("t1_grp_count", 32'(grp_count), 32'd0);

        // Fill both groups and read everything back-to-back.
        loadGrp("t2_ld0", mac_ramp(8'h00, 8'h01));
        loadGrp("t2_ld1", mac_ramp(8'h10, 8'h01));
        idle("t2_idle");
        checkField("t2_full", 32'(full), 32'd1);
        checkField("t2_wr_grp", 32'(wr_grp), 32'd0);
        checkField("t2_grp_count", 32'(grp_count), 32'd2);
        for (int k = 0; k < DEPTH; k++) readAt($sformatf("t2_rd%0d", k), k);
        idle("t2_idle2");
        checkField("t2_last_data", 32'(rd_data), 32'h19);

        // Load while full sets the sticky overflow and leaves data alone.
        loadGrp("t3_ldff", mac_ramp(8'hFF, 8'h00));
        idle("t3_idle");
        checkField("t3_overflow", 32'(overflow), 32'd1);
        checkField("t3_grp_count", 32'(grp_count), 32'd2);
        readAt("t3_rd5", 5);
        idle("t3_idle2");
        checkField("t3_rd5_data", 32'(rd_data), 32'h05);

        // Out-of-range reads.
        readAt("t4_rd20", 20);
        readAt("t4_rd31", 31);
        idle("t4_idle");
        checkField("t4_rd31_err", 32'(rd_err), 32'd1);

        // Clear wins over a simultaneous load.
        applyStimulus("t5_clr", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        loadGrp("t5_ldaa", mac_ramp(8'hAA, 8'h00));
        applyStimulus("t5_clrld", 1'b0, 1'b1, 1'b1, mac_ramp(8'h55, 8'h00), 1'b0, '0);
        idle("t5_idle");
        checkField("t5_full", 32'(full), 32'd0);
        checkField("t5_overflow", 32'(overflow), 32'd0);
        checkField("t5_wr_grp", 32'(wr_grp), 32'd0);
        readAt("t5_rd3", 3);
        idle("t5_idle2");
        checkField("t5_rd3_err", 32'(rd_err), 32'd1);

        // Read racing a load into the same group sees the old state.
        loadGrp("t6_ld20", mac_ramp(8'h20, 8'h01));
        applyStimulus("t6_ldrd", 1'b0, 1'b0, 1'b1, mac_ramp(8'h30, 8'h01), 1'b1, ADDR_W'(12));
        readAt("t6_rd12", 12);
        idle("t6_idle");
        checkField("t6_rd12_data", 32'(rd_data), 32'h32);
        checkField("t6_rd12_err", 32'(rd_err), 32'd0);
        readAt("t6_burst0", 0);
        readAt("t6_burst1", 1);
        applyStimulus("t6_rst", 1'b1, 1'b0, 1'b0, '0, 1'b1, ADDR_W'(2));
        idle("t6_idle2");
        checkField("t6_rd_valid", 32'(rd_valid), 32'd0);
        checkField("t6_full", 32'(full), 32'd0);
        checkField("t6_overflow", 32'(overflow), 32'd0);
        checkField("t6_grp_count", 32'(grp_count), 32'd0);

        // A read in the clear cycle uses the pre-clear valid bits.
        loadGrp("t7_ld40", mac_ramp(8'h40, 8'h01));
        applyStimulus("t7_clrrd", 1'b0, 1'b1, 1'b0, '0, 1'b1, ADDR_W'(4));
        readAt("t7_rd4", 4);
        idle("t7_idle");
        checkField("t7_rd4_err", 32'(rd_err), 32'd1);

        @(negedge clk);
        checkOutput();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_store_buffer.md
Name: layer_store_buffer

Overview:
- Parametrised result buffer that captures one group of LANES MAC outputs per load pulse and exposes them through an indexed read port.
- Sits between the MAC array and the next-layer input mux or argmax stage.
- Generalises the fixed 10-lane × 2-step store:
  - parametrised lane count, group count and data width;
  - internal write pointer instead of an externally supplied step index;
  - per-group valid tracking, full and overflow flags, and a clear command;
  - registered, range-checked read port.

Parameters:
DATA_W, 8, width of each stored MAC result
LANES, 10, MAC outputs captured per load
GROUPS, 2, number of load groups held (depth = LANES*GROUPS)
ADDR_W, 5, read address width; must satisfy 2**ADDR_W >= LANES*GROUPS
CNT_W, 2, width of group counter; must satisfy 2**CNT_W > GROUPS

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear of pointer, valid bits and flags (storage untouched)
ld_val  in  1  capture mac_in into next free group
mac_in  in  LANES*DATA_W  packed MAC results; lane i = bits [i*DATA_W +: DATA_W]
rd_en  in  1  read request
rd_addr  in  ADDR_W  flat read index = group*LANES + lane
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid this cycle
rd_err  out  1  qualifies rd_valid; read was out of range or hit an unwritten group
wr_grp  out  CNT_W  group index the next load will write
grp_count  out  CNT_W  number of valid groups
full  out  1  all GROUPS written
overflow  out  1  sticky; a load arrived while full

Behaviour:
- Reset (rst=1 at posedge):
  - wr_grp=0, grp_count=0, all group valid bits=0;
  - full=0, overflow=0, rd_data=0, rd_valid=0, rd_err=0.
  - Storage array is not reset. Unwritten groups read as 0 with rd_err.
- rst has priority over clr, which has priority over ld_val and over flag updates. rd_en is still serviced in a clr cycle.
- Load, ld_val=1 and full=0 and no clr:
  - store[wr_grp*LANES+i] <= lane i, for all i, in one cycle;
  - valid[wr_grp] <= 1; grp_count += 1;
  - wr_grp <= wr_grp+1, wrapping to 0 after GROUPS-1;
  - full <= 1 on the cycle that writes group GROUPS-1.
- Load while full, ld_val=1 and full=1:
  - data dropped; storage, pointer and count unchanged;
  - overflow <= 1 and holds until rst or clr.
- Clear, clr=1:
  - wr_grp=0, grp_count=0, valid=0, full=0, overflow=0;
  - a simultaneous ld_val is ignored, with no write and no overflow.
- Read:
  - rd_en at cycle N gives rd_valid=1 at cycle N+1, for exactly one cycle per request.
  - Back-to-back rd_en gives one result per cycle.
  - If rd_addr >= LANES*GROUPS, or the addressed group is not valid: rd_data=0, rd_err=1.
  - Otherwise rd_data = stored value, rd_err=0.
  - Validity is sampled at cycle N with pre-update state. A read in the same cycle as a load to the same group returns the old value; if that group was invalid, it returns 0 with rd_err.
  - A read in the same cycle as clr uses the pre-clear valid bits.
  - When rd_en=0: rd_valid=0, rd_err=0, and rd_data holds its last value.
- Data is stored verbatim, with no arithmetic or saturation; widths match DATA_W exactly.
- Derived address math uses ADDR_W+CNT_W-bit intermediates, so the out-of-range compare never truncates.

Test Plan (LANES=10, GROUPS=2, DATA_W=8):
1. Reset, then rd_en with rd_addr=0 -> next cycle rd_valid=1, rd_data=0, rd_err=1; full=0, grp_count=0.
2. ld_val with lanes 0x00..0x09, then ld_val with lanes 0x10..0x19; read addrs 0..19 back-to-back -> data 0x00..0x09, 0x10..0x19 one per cycle, rd_err=0; full=1 after the second load, wr_grp=0, grp_count=2.
3. With buffer full, ld_val with lanes 0xFF -> overflow=1; read addr 5 returns 0x05; grp_count stays 2.
4. rd_en with rd_addr=20 and with rd_addr=31 -> rd_data=0, rd_err=1 each.
5. Single load of 0xAA.. into group 0, then clr and ld_val asserted together with 0x55.. -> full=0, overflow=0, wr_grp=0, no write; read addr 3 -> 0, rd_err=1.
6. Load group 0 with 0x20..0x29, then ld_val (lanes 0x30..) and rd_en addr 12 in the same cycle -> rd_data=0, rd_err=1; the next read of addr 12 returns 0x32. Then assert rst mid-read-burst -> all flags 0, rd_valid=0 on the following cycle.
